// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, small fetch FIFO to decode.
// States: FETCH | may issue a request   WAIT | one request outstanding   DRAIN | outstanding response is wrong-path, drop it
module fetch_unit #(
  parameter int unsigned            ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0,
  parameter int unsigned            QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              dec_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [31:0]       q_instr [QDEPTH];
  logic [ADDR_W-1:0] q_pc    [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic credit;
  logic accept;
  logic push;
  logic pop;

  // A free slot is reserved before issuing, so the single outstanding response always fits.
  assign credit      = (count < CNT_W'(QDEPTH));
  assign imem_req    = ~reset & ~redirect_valid & credit & (state == S_FETCH);
  assign imem_addr   = pc;
  assign accept      = imem_req & imem_ready;
  assign push        = (state == S_WAIT) & imem_rvalid & ~redirect_valid;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & dec_ready & ~redirect_valid;
  assign instruction = q_instr[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      case (state)
        S_FETCH: state <= S_FETCH;
        S_WAIT:  state <= imem_rvalid ? S_FETCH : S_DRAIN;
        S_DRAIN: state <= imem_rvalid ? S_FETCH : S_DRAIN;
        default: state <= S_FETCH;
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc + ADDR_W'(4);
            state  <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rvalid) state <= S_FETCH;
        S_DRAIN: if (imem_rvalid) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase

      if (push) begin
        q_instr[wr_ptr] <= imem_rdata;
        q_pc[wr_ptr]    <= req_pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table, directed corner sequences,
// and a scoreboard of accepted fetch addresses compared against what decode receives.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        dec_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .dec_ready(dec_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] popped[$];
  int          lat = 1;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: scoreboard sampling mid-cycle, then the memory model at the next negedge.
  task automatic step();
    logic        acc;
    logic [63:0] acc_addr;
    logic [63:0] e;
    #1;
    acc      = imem_req & imem_ready;
    acc_addr = imem_addr;
    if (reset) begin
      exp_q.delete();
    end else if (redirect_valid) begin
      chk("redirect_no_req", {63'd0, imem_req}, 64'd0);
      exp_q.delete();
    end else begin
      if (instr_valid && dec_ready) begin
        popped.push_back(instr_pc);
        if (exp_q.size() == 0) begin
          chk("unexpected_instr_pc", instr_pc, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr_pc", instr_pc, e);
          chk("sb_instruction", {32'd0, instruction}, {32'd0, mem_word(e)});
        end
      end
      if (acc) exp_q.push_back(acc_addr);
    end
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (acc) begin
      mem_cnt  = lat;
      mem_addr = acc_addr;
    end
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; imem_ready = 1'b1; dec_ready = 1'b1;
    run(2);
    reset = 1'b0;
    popped.delete();
  endtask

  task automatic run_until_pops(input string name, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (popped.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
    if (popped.size() < n) chk(name, 64'(popped.size()), 64'(n));
  endtask

  typedef struct {
    logic        rst, rdy, dec, redir;
    logic [63:0] rpc;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    reset = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    //          rst   rdy   dec   redir rpc    req   addr    valid pc
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0,  1'b0, 64'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0,  1'b0, 64'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h4,  1'b0, 64'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'h4,  1'b1, 64'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h8,  1'b0, 64'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8,  1'b1, 64'h4};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'hC,  1'b0, 64'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'hC,  1'b1, 64'h8};

    @(negedge clk);
    lat = 1;
    step();

    // Streaming from reset with a 1-cycle memory
    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst; imem_ready = tbl[i].rdy; dec_ready = tbl[i].dec;
      redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("vec%0d_req", i), {63'd0, imem_req}, {63'd0, tbl[i].e_req});
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {63'd0, instr_valid}, {63'd0, tbl[i].e_valid});
      if (tbl[i].e_valid || tbl[i].rst) chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].e_pc);
      if (tbl[i].rst) chk($sformatf("vec%0d_instr", i), {32'd0, instruction}, 64'd0);
      step();
    end

    // Back-pressure fills the FIFO and stops requests
    do_reset();
    dec_ready = 1'b0;
    run(10);
    #1;
    chk("fill_req", {63'd0, imem_req}, 64'd0);
    chk("fill_valid", {63'd0, instr_valid}, 64'd1);
    chk("fill_head_pc", instr_pc, 64'h0);
    chk("fill_next_addr", imem_addr, 64'h8);
    dec_ready = 1'b1;
    run_until_pops("fill_release_timeout", 3, 20);
    if (popped.size() >= 3) begin
      chk("fill_pop0", popped[0], 64'h0);
      chk("fill_pop1", popped[1], 64'h4);
      chk("fill_pop2", popped[2], 64'h8);
    end

    // Memory stall holds the request
    do_reset();
    for (int b = 0; b < 30; b++) begin
      #1;
      if (imem_req && imem_addr == 64'h10) break;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      #1;
      chk($sformatf("stall%0d_req", i), {63'd0, imem_req}, 64'd1);
      chk($sformatf("stall%0d_addr", i), imem_addr, 64'h10);
      step();
    end
    imem_ready = 1'b1;
    run_until_pops("stall_timeout", 6, 20);

    // Redirect while waiting; response arrives next cycle and is dropped
    do_reset();
    lat = 2;
    #1; chk("t4_req_c0", {63'd0, imem_req}, 64'd1);
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h203;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_drain_req", {63'd0, imem_req}, 64'd0);
    chk("t4_drain_valid", {63'd0, instr_valid}, 64'd0);
    step();
    #1;
    chk("t4_target_req", {63'd0, imem_req}, 64'd1);
    chk("t4_target_addr", imem_addr, 64'h200);
    chk("t4_gap_valid", {63'd0, instr_valid}, 64'd0);
    lat = 1;
    step();
    run_until_pops("t4_timeout", 1, 20);
    if (popped.size() >= 1) chk("t4_first_pc", popped[0], 64'h200);

    // Redirect coincident with rvalid and a decode pop
    do_reset();
    lat = 1;
    dec_ready = 1'b0;
    run(3);
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300;
    #1;
    chk("t5_pre_valid", {63'd0, instr_valid}, 64'd1);
    chk("t5_pre_rvalid_seen", {63'd0, imem_rvalid}, 64'd1);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t5_post_valid", {63'd0, instr_valid}, 64'd0);
    chk("t5_post_req", {63'd0, imem_req}, 64'd1);
    chk("t5_post_addr", imem_addr, 64'h300);
    chk("t5_no_pops", 64'(popped.size()), 64'd0);
    run_until_pops("t5_timeout", 1, 20);
    if (popped.size() >= 1) chk("t5_first_pc", popped[0], 64'h300);

    // Redirect to the top of the address space, then reset mid-WAIT
    do_reset();
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t6_top_req", {63'd0, imem_req}, 64'd1);
    chk("t6_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    #1;
    chk("t6_wrap_addr", imem_addr, 64'h0);
    step();
    #1;
    chk("t6_wrap_req", {63'd0, imem_req}, 64'd1);
    lat = 2;
    step();
    reset = 1'b1;
    #1;
    chk("t6_rst_req", {63'd0, imem_req}, 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("t6_after_rst_req", {63'd0, imem_req}, 64'd1);
    chk("t6_after_rst_addr", imem_addr, 64'h0);
    chk("t6_after_rst_valid", {63'd0, instr_valid}, 64'd0);
    step();
    #1;
    chk("t6_stale_ignored", {63'd0, instr_valid}, 64'd0);
    step();
    run_until_pops("t6_timeout", 2, 20);
    if (popped.size() >= 2) begin
      chk("t6_pop_top", popped[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t6_pop_reset_pc", popped[1], 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
